// File: rtl/gpio_stream_pkg.sv
// Shared types for the GPIO pixel capture to UART streaming path.
package gpio_stream_pkg;

    typedef enum logic [1:0] {
        TAG_R   = 2'd0,
        TAG_G   = 2'd1,
        TAG_B   = 2'd2,
        TAG_EOI = 2'd3
    } tag_e;

    localparam logic [7:0] HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_LANE,
        ST_STOP_GAP
    } state_e;

    typedef struct packed {
        tag_e        tag;
        logic [31:0] data;
    } entry_t;

    function automatic logic [7:0] header_byte(input tag_e t);
        return HDR_BASE | {6'b0, t};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; done marks the final stop-bit cycle so bytes can chain.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          active;

    assign done = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);

    // Start bit goes out on load; each bit boundary shifts the next bit (stop bit is the fill).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '1;
        end else if (start) begin
            tx       <= 1'b0;
            shreg    <= {1'b1, byte_in};
            active   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_uart_streamer.sv
// Captures GPIO pixel words and end-of-image events, queues them, and sends each as a UART frame.
module gpio_uart_streamer
    import gpio_stream_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [127:0]                gpio,
    input  logic                        gpio_en_r,
    input  logic                        gpio_en_g,
    input  logic                        gpio_en_b,
    input  logic                        gpio_en,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    entry_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            gpio_en_q;
    state_e          state;
    entry_t          frame;
    entry_t          head;
    logic [1:0]      byte_cnt;

    logic            eoi_req;
    logic [2:0]      n_req;
    logic            push_req;
    logic            conflict;
    logic            full;
    logic            push_ok;
    logic            pop;
    entry_t          push_entry;
    logic [PW:0]     count_nxt;
    logic            uart_start;
    logic            uart_done;
    logic [7:0]      uart_byte;
    logic            gpio_unused;

    assign head        = mem[rd_ptr];
    assign gpio_unused = ^{gpio[127:104], gpio[95:72], gpio[63:40], gpio[31:8]};

    // Pick at most one push per cycle (R > G > B > EOI) and flag any request that loses or hits a full FIFO.
    always_comb begin
        eoi_req         = gpio_en & ~gpio_en_q;
        n_req           = 3'(gpio_en_r) + 3'(gpio_en_g) + 3'(gpio_en_b) + 3'(eoi_req);
        push_req        = (n_req != 3'd0);
        conflict        = (n_req > 3'd1);
        push_entry      = '0;
        push_entry.data = {gpio[103:96], gpio[71:64], gpio[39:32], gpio[7:0]};
        if (gpio_en_r) begin
            push_entry.tag = TAG_R;
        end else if (gpio_en_g) begin
            push_entry.tag = TAG_G;
        end else if (gpio_en_b) begin
            push_entry.tag = TAG_B;
        end else begin
            push_entry.tag  = TAG_EOI;
            push_entry.data = '0;
        end
        full      = (fifo_count == DEPTH_C);
        push_ok   = push_req & ~full;
        pop       = (state == ST_IDLE) && (fifo_count != '0);
        count_nxt = fifo_count + (PW + 1)'(push_ok) - (PW + 1)'(pop);
    end

    // Decide when the serialiser gets its next byte and which byte of the frame that is.
    always_comb begin
        uart_start = 1'b0;
        uart_byte  = header_byte(head.tag);
        case (state)
            ST_IDLE: begin
                uart_start = pop;
            end
            ST_HDR: begin
                uart_start = uart_done && (frame.tag != TAG_EOI);
                uart_byte  = frame.data[31:24];
            end
            ST_LANE: begin
                uart_start = uart_done && (byte_cnt != 2'd3);
                case (byte_cnt)
                    2'd0:    uart_byte = frame.data[23:16];
                    2'd1:    uart_byte = frame.data[15:8];
                    default: uart_byte = frame.data[7:0];
                endcase
            end
            default: begin
                uart_start = 1'b0;
            end
        endcase
    end

    // FIFO storage; stale contents are harmless because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the end-of-image edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            gpio_en_q  <= 1'b0;
        end else begin
            gpio_en_q  <= gpio_en;
            fifo_count <= count_nxt;
            overflow   <= overflow | conflict | (push_req & full);
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Frame sequencer: header, four lane bytes (colour only), one idle gap cycle; busy tracks the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            frame    <= '0;
            byte_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= (count_nxt != '0) || (state == ST_HDR) || (state == ST_LANE) || pop;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        frame <= head;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (uart_done) begin
                        byte_cnt <= '0;
                        state    <= (frame.tag == TAG_EOI) ? ST_STOP_GAP : ST_LANE;
                    end
                end
                ST_LANE: begin
                    if (uart_done) begin
                        if (byte_cnt == 2'd3) begin
                            state <= ST_STOP_GAP;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (uart_start),
        .byte_in (uart_byte),
        .tx      (tx),
        .done    (uart_done)
    );

endmodule

// File: tb/tb_gpio_uart_streamer.sv
// Directed bench for gpio_uart_streamer with a UART byte decoder on tx.
module tb_gpio_uart_streamer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] gpio = '0;
    logic         gpio_en_r = 1'b0;
    logic         gpio_en_g = 1'b0;
    logic         gpio_en_b = 1'b0;
    logic         gpio_en = 1'b0;
    logic         tx;
    logic         busy;
    logic         overflow;
    logic [2:0]   fifo_count;

    int           tests_run = 0;
    int           tests_failed = 0;
    int           cyc = 0;
    int           frame_err = 0;
    logic [7:0]   rx_q [$];
    int           rx_t [$];

    gpio_uart_streamer #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio       (gpio),
        .gpio_en_r  (gpio_en_r),
        .gpio_en_g  (gpio_en_g),
        .gpio_en_b  (gpio_en_b),
        .gpio_en    (gpio_en),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge names the cycle that began at the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Decode 8N1 bytes from tx, recording each byte and the cycle its start bit appeared.
    initial begin : decoder
        logic [7:0] b;
        int         s;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                s = cyc;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
                rx_t.push_back(s);
            end
        end
    end

    // Hard stop in case something hangs.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic b, input logic e,
                                 input logic [127:0] d, output int pc);
        @(negedge clk);
        gpio      = d;
        gpio_en_r = r;
        gpio_en_g = g;
        gpio_en_b = b;
        gpio_en   = e;
        pc        = cyc;
    endtask

    function automatic logic [127:0] lanes(input logic [7:0] b3, input logic [7:0] b2,
                                           input logic [7:0] b1, input logic [7:0] b0);
        return {24'hA5C3E1, b3, 24'h5A3C1E, b2, 24'h0F0F0F, b1, 24'hF0F0F0, b0};
    endfunction

    task automatic waitBytes(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) checkOutput(tag, rx_q.size(), n);
    endtask

    task automatic checkFrame(input int base, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                              input string tag);
        logic [7:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[base + i]}, {24'h0, e[i]});
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        rx_q.delete();
        rx_t.delete();
    endtask

    initial begin : main
        int pc;
        int pc0;
        int dummy;
        int k;
        int gap;
        int lowcnt;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single R push
        applyStimulus(1, 0, 0, 0, lanes(8'h11, 8'h22, 8'h33, 8'h44), pc);
        applyStimulus(0, 0, 0, 0, '0, dummy);
        checkOutput("s1_count_after_push", fifo_count, 1);
        checkOutput("s1_busy_after_push", busy, 1);
        @(negedge clk);
        checkOutput("s1_count_after_pop", fifo_count, 0);
        checkOutput("s1_tx_start", tx, 0);
        waitBytes(5, 400, "s1_timeout");
        checkFrame(0, 8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, "s1");
        checkOutput("s1_latency", rx_t[0] - pc, 2);
        checkOutput("s1_frame_span", rx_t[4] - rx_t[0], 4 * 10 * CPB);
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("s1_busy_fall", cyc - rx_t[0], 201);

        // End-of-image held high for 10 cycles
        doReset();
        applyStimulus(0, 0, 0, 1, '0, pc);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 1, '0, dummy);
        applyStimulus(0, 0, 0, 0, '0, dummy);
        waitBytes(1, 200, "s2_timeout");
        repeat (100) @(negedge clk);
        checkOutput("s2_nbytes", rx_q.size(), 1);
        checkOutput("s2_hdr", {24'h0, rx_q[0]}, 32'hA3);
        checkOutput("s2_latency", rx_t[0] - pc, 2);
        checkOutput("s2_overflow", overflow, 0);

        // R, G, B on consecutive cycles
        doReset();
        applyStimulus(1, 0, 0, 0, lanes(8'h01, 8'h02, 8'h03, 8'h04), dummy);
        applyStimulus(0, 1, 0, 0, lanes(8'h05, 8'h06, 8'h07, 8'h08), dummy);
        applyStimulus(0, 0, 1, 0, lanes(8'h09, 8'h0A, 8'h0B, 8'h0C), dummy);
        applyStimulus(0, 0, 0, 0, '0, dummy);
        waitBytes(15, 1200, "s3_timeout");
        checkFrame(0, 8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, "s3_r");
        checkFrame(5, 8'hA1, 8'h05, 8'h06, 8'h07, 8'h08, "s3_g");
        checkFrame(10, 8'hA2, 8'h09, 8'h0A, 8'h0B, 8'h0C, "s3_b");
        gap = rx_t[5] - rx_t[4] - 10 * CPB;
        checkOutput("s3_gap_rg", (gap >= 1 && gap <= 2), 1);
        gap = rx_t[10] - rx_t[9] - 10 * CPB;
        checkOutput("s3_gap_gb", (gap >= 1 && gap <= 2), 1);
        checkOutput("s3_overflow", overflow, 0);

        // Six pushes back to back: five accepted, the sixth dropped
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 0, lanes(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)),
                          (i == 0) ? pc0 : dummy);
        end
        applyStimulus(0, 0, 0, 0, '0, dummy);
        checkOutput("s4_count_full", fifo_count, 4);
        checkOutput("s4_overflow_set", overflow, 1);
        waitBytes(25, 2000, "s4_timeout");
        repeat (100) @(negedge clk);
        checkOutput("s4_nbytes", rx_q.size(), 25);
        for (int f = 0; f < 5; f++) begin
            checkFrame(5 * f, 8'hA0, 8'(8'h10 + f), 8'(8'h20 + f), 8'(8'h30 + f), 8'(8'h40 + f),
                       $sformatf("s4_f%0d", f));
        end
        checkOutput("s4_overflow_sticky", overflow, 1);
        doReset();
        checkOutput("s4_overflow_cleared", overflow, 0);

        // R and B requested together
        applyStimulus(1, 0, 1, 0, lanes(8'h55, 8'h66, 8'h77, 8'h88), dummy);
        applyStimulus(0, 0, 0, 0, '0, dummy);
        waitBytes(5, 400, "s5_timeout");
        repeat (100) @(negedge clk);
        checkOutput("s5_nbytes", rx_q.size(), 5);
        checkFrame(0, 8'hA0, 8'h55, 8'h66, 8'h77, 8'h88, "s5");
        checkOutput("s5_overflow", overflow, 1);
        checkOutput("framing_errors", frame_err, 0);

        // Reset during the third byte of a frame
        doReset();
        applyStimulus(1, 0, 0, 0, lanes(8'hC3, 8'h00, 8'h5A, 8'h81), pc);
        applyStimulus(0, 1, 0, 0, lanes(8'h01, 8'h02, 8'h03, 8'h04), dummy);
        applyStimulus(0, 0, 0, 0, '0, dummy);
        while (cyc < pc + 2 + 90) @(negedge clk);
        checkOutput("s6_tx_mid_byte", tx, 0);
        checkOutput("s6_count_before", fifo_count, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("s6_tx_in_reset", tx, 1);
        checkOutput("s6_count_in_reset", fifo_count, 0);
        checkOutput("s6_busy_in_reset", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lowcnt++;
        end
        checkOutput("s6_tx_idle_after", lowcnt, 0);
        checkOutput("s6_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
